// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush sequencer for the 5-stage pipeline
// Optional HAZ_PERF_EN adds a saturating stall_cnt output.
module pipeline_hazard_ctrl #(
    parameter int DRAIN_CYCLES = 3,
    parameter int MEM_TIMEOUT  = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_use_rs,
    input  logic       id_use_rt,
    input  logic       id_is_store,
    input  logic [4:0] ex_rd,
    input  logic       ex_reg_write,
    input  logic       ex_mem_to_reg,
    input  logic       ex_branch_taken,
    input  logic       mem_req,
    input  logic       mem_ready,
    input  logic       halt_req,
    input  logic       resume_req,
    output logic       stall_f,
    output logic       stall_d,
    output logic       flush_d,
    output logic       flush_e,
    output logic       stall_m,
    output logic       halted,
    output logic       mem_err
`ifdef HAZ_PERF_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);
    localparam logic [7:0] WAIT_LAST  = 8'(MEM_TIMEOUT - 1);

    state_t     state, stateNext;
    logic [3:0] drainCnt, drainNext;
    logic [7:0] waitCnt, waitNext;
    logic       rawWait, timeoutHit, memWait, loadUse;
    logic       stallF, stallD, flushD, flushE, stallM;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            drainCnt <= 4'd0;
            waitCnt  <= 8'd0;
        end else begin
            state    <= stateNext;
            drainCnt <= drainNext;
            waitCnt  <= waitNext;
        end
    end

    always_comb begin
        rawWait    = mem_req & ~mem_ready;
        timeoutHit = rawWait & (waitCnt == WAIT_LAST);
        memWait    = rawWait & ~timeoutHit;
        // A store's rt is fed by the MEM-stage forwarding path, so it never stalls.
        loadUse    = ex_mem_to_reg & ex_reg_write & (ex_rd != 5'd0) &
                     ((id_use_rs & (id_rs == ex_rd)) |
                      (id_use_rt & (id_rt == ex_rd) & ~id_is_store));

        stateNext = state;
        drainNext = drainCnt;
        waitNext  = memWait ? waitCnt + 8'd1 : 8'd0;
        stallF    = 1'b0;
        stallD    = 1'b0;
        flushD    = 1'b0;
        flushE    = 1'b0;
        stallM    = 1'b0;

        if (memWait) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallM = 1'b1;
        end else if (ex_branch_taken && state != HALTED) begin
            flushD = 1'b1;
            flushE = 1'b1;
        end else if (state == HALTED || state == DRAIN || loadUse) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
        end

        if (!memWait) begin
            case (state)
                RUN: if (halt_req) begin
                    stateNext = DRAIN;
                    drainNext = DRAIN_LOAD;
                end
                DRAIN: begin
                    if (drainCnt == 4'd0) stateNext = HALTED;
                    else drainNext = drainCnt - 4'd1;
                end
                HALTED: if (resume_req) stateNext = RUN;
                default: stateNext = RUN;
            endcase
        end
    end

    assign stall_f = rst_n & stallF;
    assign stall_d = rst_n & stallD;
    assign flush_d = rst_n & flushD;
    assign flush_e = rst_n & flushE;
    assign stall_m = rst_n & stallM;
    assign halted  = rst_n & (state == HALTED);
    assign mem_err = rst_n & timeoutHit;

`ifdef HAZ_PERF_EN
    logic [31:0] stallCnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stallCnt <= 32'd0;
        else if (stallD && state != HALTED && stallCnt != 32'hFFFF_FFFF)
            stallCnt <= stallCnt + 32'd1;
    end

    assign stall_cnt = stallCnt;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_rs, id_rt, ex_rd;
    logic       id_use_rs, id_use_rt, id_is_store;
    logic       ex_reg_write, ex_mem_to_reg, ex_branch_taken;
    logic       mem_req, mem_ready, halt_req, resume_req;
    logic       stall_f, stall_d, flush_d, flush_e, stall_m, halted, mem_err;
`ifdef HAZ_PERF_EN
    logic [31:0] stall_cnt;
`endif

    int checkCount = 0;
    int errorCount = 0;

    // Output vector order: stall_f stall_d flush_d flush_e stall_m halted mem_err
    localparam logic [6:0] O_IDLE  = 7'b0000000;
    localparam logic [6:0] O_BUB   = 7'b1101000;
    localparam logic [6:0] O_BR    = 7'b0011000;
    localparam logic [6:0] O_WAIT  = 7'b1100100;
    localparam logic [6:0] O_HALT  = 7'b1101010;
    localparam logic [6:0] O_ERR   = 7'b0000001;

    pipeline_hazard_ctrl #(.DRAIN_CYCLES(3), .MEM_TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_is_store(id_is_store), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready), .halt_req(halt_req),
        .resume_req(resume_req), .stall_f(stall_f), .stall_d(stall_d),
        .flush_d(flush_d), .flush_e(flush_e), .stall_m(stall_m),
        .halted(halted), .mem_err(mem_err)
`ifdef HAZ_PERF_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] outs();
        return {stall_f, stall_d, flush_d, flush_e, stall_m, halted, mem_err};
    endfunction

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            errorCount++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        id_rs = 0; id_rt = 0; ex_rd = 0;
        id_use_rs = 0; id_use_rt = 0; id_is_store = 0;
        ex_reg_write = 0; ex_mem_to_reg = 0; ex_branch_taken = 0;
        mem_req = 0; mem_ready = 0; halt_req = 0; resume_req = 0;
    endtask

    task automatic setLoad(input logic [4:0] rd);
        ex_rd = rd; ex_reg_write = 1; ex_mem_to_reg = 1;
    endtask

    initial begin
        clearInputs();
        rst_n = 0;
        ex_branch_taken = 1; mem_req = 1; halt_req = 1;
        setLoad(5'd5); id_rs = 5; id_use_rs = 1;
        #12;
        checkEq("reset_outs", 32'(outs()), 32'(O_IDLE));
        rst_n = 1;
        clearInputs();
        #1;
        checkEq("idle", 32'(outs()), 32'(O_IDLE));
        tick();

        setLoad(5'd5); id_rs = 5; id_use_rs = 1; #1;
        checkEq("lu_rs", 32'(outs()), 32'(O_BUB));
        id_use_rs = 0; id_rs = 0; id_rt = 5; id_use_rt = 1; id_is_store = 1; #1;
        checkEq("sw_rt_nostall", 32'(outs()), 32'(O_IDLE));
        id_is_store = 0; #1;
        checkEq("lu_rt", 32'(outs()), 32'(O_BUB));
        ex_rd = 0; id_rt = 0; #1;
        checkEq("rd0_nostall", 32'(outs()), 32'(O_IDLE));
        ex_rd = 5; id_rt = 5; ex_mem_to_reg = 0; #1;
        checkEq("nonload_nostall", 32'(outs()), 32'(O_IDLE));
        ex_mem_to_reg = 1; ex_branch_taken = 1; #1;
        checkEq("branch_over_lu", 32'(outs()), 32'(O_BR));
        clearInputs();
        tick();

        mem_req = 1; mem_ready = 0;
        for (int i = 1; i <= 14; i++) begin
            #1;
            checkEq($sformatf("to_wait%0d", i), 32'(outs()), 32'(O_WAIT));
            tick();
        end
        checkEq("to_err", 32'(outs()), 32'(O_ERR));
        tick();
        checkEq("to_restart", 32'(outs()), 32'(O_WAIT));
        clearInputs();
        #1;
        rst_n = 0; #2; rst_n = 1;
        tick();

        setLoad(5'd7); id_rs = 7; id_use_rs = 1; #1;
        checkEq("perf_lu", 32'(outs()), 32'(O_BUB));
        tick();
        clearInputs(); #1;
        checkEq("lu_one_cycle", 32'(outs()), 32'(O_IDLE));
        tick();
        mem_req = 1; mem_ready = 0;
        for (int i = 1; i <= 4; i++) begin
            #1;
            checkEq($sformatf("wait4_%0d", i), 32'(outs()), 32'(O_WAIT));
            tick();
        end
        mem_ready = 1; #1;
        checkEq("wait4_done", 32'(outs()), 32'(O_IDLE));
        tick();
        clearInputs();

        halt_req = 1; #1;
        checkEq("halt_req_run", 32'(outs()), 32'(O_IDLE));
        tick();
        halt_req = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checkEq($sformatf("drain%0d", i), 32'(outs()), 32'(O_BUB));
            tick();
        end
        checkEq("halted_edge3", 32'(outs()), 32'(O_HALT));
`ifdef HAZ_PERF_EN
        checkEq("stall_cnt_8", stall_cnt, 32'd8);
`endif
        halt_req = 1;
        tick(); tick(); tick();
        halt_req = 0;
        checkEq("halted_hold", 32'(outs()), 32'(O_HALT));
`ifdef HAZ_PERF_EN
        checkEq("stall_cnt_hold", stall_cnt, 32'd8);
`endif
        resume_req = 1;
        tick();
        resume_req = 0; #1;
        checkEq("resume", 32'(outs()), 32'(O_IDLE));
        tick();

        halt_req = 1;
        tick();
        halt_req = 0;
        checkEq("dw_drain_a", 32'(outs()), 32'(O_BUB));
        tick();
        mem_req = 1; mem_ready = 0; #1;
        checkEq("dw_wait1", 32'(outs()), 32'(O_WAIT));
        tick();
        checkEq("dw_wait2", 32'(outs()), 32'(O_WAIT));
        tick();
        mem_req = 0; #1;
        checkEq("dw_drain_b", 32'(outs()), 32'(O_BUB));
        tick();
        checkEq("dw_edge4", 32'(outs()), 32'(O_BUB));
        tick();
        checkEq("dw_halted_edge5", 32'(outs()), 32'(O_HALT));
        resume_req = 1;
        tick();
        resume_req = 0;

        halt_req = 1;
        tick();
        halt_req = 0;
        checkEq("rst_drain", 32'(outs()), 32'(O_BUB));
        #2; rst_n = 0; #1;
        checkEq("rst_async", 32'(outs()), 32'(O_IDLE));
        #2; rst_n = 1;
        tick();
        checkEq("rst_run", 32'(outs()), 32'(O_IDLE));
        tick();
        checkEq("rst_run2", 32'(outs()), 32'(O_IDLE));
`ifdef HAZ_PERF_EN
        checkEq("stall_cnt_rst", stall_cnt, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush sequencer for the 5-stage MIPS pipeline, sitting beside the MEM-stage lw→sw forwarding unit. It detects load-use hazards in ID, flushes on taken branches resolved in EX, freezes the pipeline while data memory is not ready (with timeout), and runs a halt/drain/resume sequence for debug and exception entry. Its outputs drive the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB register enables and clears.

## Interface
- DRAIN_CYCLES, 3: cycles of bubble injection before HALTED (EX, MEM, WB drain); legal 1..15.
- MEM_TIMEOUT, 15: consecutive not-ready cycles before the memory stall is forcibly released; legal 2..255.
- clk  in  1  pipeline clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_rs, id_rt  in  5  source registers of the instruction in ID.
- id_use_rs, id_use_rt  in  1  ID instruction actually reads rs / rt.
- id_is_store  in  1  ID instruction is sw (rt is store data).
- ex_rd  in  5  destination register of the instruction in EX.
- ex_reg_write, ex_mem_to_reg  in  1  EX instruction writes a register / is a load.
- ex_branch_taken  in  1  branch/jump in EX resolved taken this cycle.
- mem_req  in  1  MEM stage holds a load or store.
- mem_ready  in  1  data memory completes the access this cycle.
- halt_req  in  1  level request to halt.
- resume_req  in  1  level request to leave HALTED.
- stall_f  out  1  hold PC.
- stall_d  out  1  hold IF/ID.
- flush_d  out  1  clear IF/ID to bubble.
- flush_e  out  1  clear ID/EX to bubble.
- stall_m  out  1  hold ID/EX, EX/MEM and MEM/WB (full freeze).
- halted  out  1  pipeline drained and parked.
- mem_err  out  1  one-cycle pulse on memory timeout.

## Operation
- State: RUN, DRAIN, HALTED; 4-bit drain_cnt; 8-bit wait_cnt.
- mem_wait = mem_req & !mem_ready & (wait_cnt != MEM_TIMEOUT-1).
- lu = ex_mem_to_reg & ex_reg_write & ex_rd!=0 & ((id_use_rs & id_rs==ex_rd) | (id_use_rt & id_rt==ex_rd & !id_is_store)); sw rt dependence does not stall, the forwarding unit covers it.
- Priority per cycle, highest first:
  - mem_wait: stall_f=stall_d=stall_m=1, flushes 0; no state or drain_cnt advance.
  - ex_branch_taken (RUN or DRAIN): flush_d=flush_e=1, stall_f=0 (PC loads target), stall_d=0.
  - HALTED: stall_f=stall_d=flush_e=1.
  - DRAIN: stall_f=stall_d=flush_e=1.
  - RUN & lu: stall_f=stall_d=flush_e=1 (one bubble).
  - otherwise all 0.
- wait_cnt: increments while mem_req & !mem_ready, clears otherwise. At MEM_TIMEOUT-1 the stall is released, mem_err=1 that cycle, and wait_cnt clears next edge.
- RUN→DRAIN when halt_req, not mem_wait; drain_cnt loads DRAIN_CYCLES-1.
- DRAIN: drain_cnt decrements on non-mem_wait cycles; at 0 →HALTED. halt_req deassertion does not abort.
- HALTED: halted=1; resume_req →RUN next edge; halt_req ignored.
- resume_req in RUN/DRAIN ignored.

## Timing
- Reset: state RUN, counters 0. While rst_n low, all outputs are 0 regardless of inputs (halted=0, mem_err=0).
- Outputs are combinational from registered state plus current inputs; zero-cycle hazard response.
- Load-use costs exactly 1 cycle; a second lu the next cycle is impossible (load has moved to MEM).
- Halt latency: halt_req sampled at edge N → halted=1 from edge N+DRAIN_CYCLES, plus one cycle per mem_wait cycle.
- resume_req at edge N → all outputs 0 in cycle N+1 (absent other hazards).
- Reset mid-DRAIN or mid-wait: immediate return to RUN, counters cleared.

## Configuration
- HAZ_PERF_EN defined: adds output stall_cnt [31:0], reset 0, incremented on every cycle with stall_d=1 and state!=HALTED, saturating at 32'hFFFFFFFF.
- Undefined: port and counter absent; all other behaviour identical.

## Test plan
- Load-use: ex_rd=5, ex_mem_to_reg=ex_reg_write=1, id_rs=5, id_use_rs=1 -> stall_f=stall_d=flush_e=1 one cycle; same with id_is_store=1 and only rt=5 -> no stall; ex_rd=0 -> no stall.
- Branch: ex_branch_taken=1 coincident with lu -> flush_d=flush_e=1, stall_f=0.
- Memory wait: mem_req=1, mem_ready low 4 cycles -> stall_m=1 for 4 cycles, mem_err=0; mem_ready low indefinitely with MEM_TIMEOUT=15 -> stall cycles 1..14, mem_err pulse in cycle 15.
- Halt: halt_req at edge 0, DRAIN_CYCLES=3 -> halted=1 from edge 3; mem_wait 2 cycles inside DRAIN -> halted from edge 5; resume_req -> outputs 0 next cycle.
- Reset: rst_n low during DRAIN -> outputs 0 asynchronously, state RUN after release.
- HAZ_PERF_EN: 1 lu + 4 mem-wait cycles + halt with DRAIN_CYCLES=3 -> stall_cnt=8, unchanged while HALTED.
